divider: RTL and testbench
==========================

# divider

Iterative radix-2 restoring divider implementing the RV32M DIV, DIVU, REM and REMU operations, one quotient bit per cycle. It sits beside the ALU in the execute stage and raises `div_stall` so the pipeline holds the instruction until the result is ready. RISC-V special cases (divide-by-zero, signed overflow) are resolved on a one-cycle fast path with no iteration.

## Interface
- `WORD_WIDTH`, 32: operand and result width; the iteration counter is sized log2(`WORD_WIDTH`) bits.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `nrst`  in  1  reset, synchronous, active-low.
- `start`  in  1  division request; held high by the stalled pipeline until `valid`.
- `div_op`  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `op_a`  in  `WORD_WIDTH`  dividend.
- `op_b`  in  `WORD_WIDTH`  divisor.
- `flush`  in  1  synchronous abort of any in-flight division.
- `res`  out  `WORD_WIDTH`  result; registered; holds its value until the next completion.
- `valid`  out  1  registered; high for exactly one cycle when `res` is new.
- `busy`  out  1  high in CALC, FIX and DONE.
- `div_stall`  out  1  combinational, equal to `start & ~valid`.

## Operation
- States:
  - IDLE: sample `start`.
  - CALC: iterate, 32 cycles.
  - FIX: apply signs and load `res`.
  - DONE: `valid` = 1.
- IDLE, `start`=1, `flush`=0:
  - Latch `div_op`, the signedness, and the sign of each operand.
  - Latch |`op_a`| and |`op_b`| for signed ops; raw values for unsigned ops.
  - If `op_b`==0 or signed overflow: load `res` with the special value and go to DONE.
  - Otherwise go to CALC with counter = 0, remainder = 0, shift register = dividend magnitude.
- Special values:
  - Divide-by-zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give `op_a` unmodified.
  - Overflow (DIV/REM only, `op_a`=0x80000000, `op_b`=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC, each cycle:
  - Form trial = {rem, dvd[31]} − {0, divisor}, 33-bit.
  - If trial ≥ 0: rem = trial[31:0] and shift in quotient bit 1.
  - Else: rem = {rem[30:0], dvd[31]} and shift in 0.
  - Counter increments; after counter = 31 go to FIX.
- FIX:
  - Quotient is negated if the operation is signed and the operand signs differ.
  - Remainder is negated if the operation is signed and the dividend is negative.
  - Load `res` with the quotient (DIV/DIVU) or the remainder (REM/REMU).
  - Go to DONE.
- DONE: `valid` = 1; unconditionally return to IDLE. `start` is not sampled in DONE.
- Operand and `div_op` changes after acceptance are ignored.
- 0x80000000 magnitude: handled as unsigned 32-bit; no overflow in the abs step.
- `flush`: from any state, go to IDLE next edge, with `valid` = 0 and `res` unchanged. `flush` has priority over `start`.
- Reset (`nrst`=0 at an edge, in any state, including mid-operation):
  - State = IDLE, counter = 0.
  - `res` = 0, `valid` = 0, `busy` = 0.
  - All latched operands cleared.

## Timing
- Cycle 0 is the cycle in which IDLE samples `start`=1.
- Normal path: CALC covers cycles 1–32, FIX is cycle 33, DONE is cycle 34; `valid` is high in cycle 34 only.
- Fast path (zero divisor or overflow): DONE in cycle 1; `valid` high in cycle 1.
- `div_stall`:
  - High from cycle 0 through the cycle before DONE.
  - Low in the DONE cycle, so the pipeline advances on the DONE edge.
- Back-to-back divisions with `start` held high: the next request is sampled in the IDLE cycle after DONE. That gives 35 cycles per normal division and 2 per fast-path division.
- `start` arriving while `busy` (non-DONE) states are active has no additional effect.

## Test plan
- DIVU 100/7 → `res`=14 with `valid` in cycle 34. Then REMU 100/7 → `res`=2. `div_stall` high for cycles 0–33.
- Signed ops:
  - DIV 0xFFFFFFF9/2 (−7/2) → 0xFFFFFFFD (−3).
  - REM −7/2 → 0xFFFFFFFF (−1).
  - DIV 7/0xFFFFFFFE → 0xFFFFFFFD.
  - DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
- Divide-by-zero:
  - DIV 5/0 → 0xFFFFFFFF with `valid` in cycle 1.
  - REMU 5/0 → 5.
  - REM 0x80000000/0 → 0x80000000.
- Overflow:
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 with `valid` in cycle 1.
  - REM of the same operands → 0.
  - DIVU 0x80000000/0xFFFFFFFF → 0.
- Flush:
  - `flush` in cycle 10 → `busy` = 0 in cycle 11, no `valid` pulse, `res` keeps its prior value.
  - A following DIVU 9/3 → 3 with normal latency.
- Reset and back-to-back:
  - `nrst`=0 in cycle 20 → `res` = 0, `valid` = 0, `busy` = 0 next cycle.
  - Two DIVUs (50/5, then 81/9) with `start` held high → `valid` pulses 35 cycles apart, with `res` = 10 then 9.

Source files
------------

// File: rtl/divider_if.sv
// Execute-stage handshake between the pipeline and the iterative divider.
interface divider_if #(parameter int WORD_WIDTH = 32);
    logic                  start;
    logic [1:0]            div_op;
    logic [WORD_WIDTH-1:0] op_a;
    logic [WORD_WIDTH-1:0] op_b;
    logic                  flush;
    logic [WORD_WIDTH-1:0] res;
    logic                  valid;
    logic                  busy;
    logic                  div_stall;

    modport master (
        output start, div_op, op_a, op_b, flush,
        input  res, valid, busy, div_stall
    );

    modport slave (
        input  start, div_op, op_a, op_b, flush,
        output res, valid, busy, div_stall
    );
endinterface

// File: rtl/divider.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle,
// with a single-cycle path for divide-by-zero and signed overflow.
module divider #(
    parameter int WORD_WIDTH = 32
) (
    input  logic     CLK,
    input  logic     nrst,
    divider_if.slave bus
);
    localparam int CW = $clog2(WORD_WIDTH);
    localparam logic [WORD_WIDTH-1:0] ONE     = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] ZERO    = {WORD_WIDTH{1'b0}};
    localparam logic [WORD_WIDTH-1:0] ALL1    = {WORD_WIDTH{1'b1}};
    localparam logic [WORD_WIDTH-1:0] MIN_NEG = {1'b1, {(WORD_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]         CNT_END = CW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [1:0]            r_op;
    logic                  r_neg_a;
    logic                  r_neg_b;
    logic [WORD_WIDTH-1:0] r_divisor;
    logic [WORD_WIDTH-1:0] r_dvd;   // dividend shifts out, quotient shifts in
    logic [WORD_WIDTH-1:0] r_rem;
    logic [WORD_WIDTH-1:0] r_res;
    logic                  r_valid;
    logic                  r_busy;

    logic                  w_signed;
    logic                  w_dbz;
    logic                  w_ovf;
    logic [WORD_WIDTH-1:0] w_abs_a;
    logic [WORD_WIDTH-1:0] w_abs_b;
    logic [WORD_WIDTH-1:0] w_special;
    logic [WORD_WIDTH:0]   w_trial;
    logic [WORD_WIDTH-1:0] w_quot;
    logic [WORD_WIDTH-1:0] w_remf;
    logic [WORD_WIDTH-1:0] w_fix_res;
    logic                  w_r_signed;

    // Request decode, trial subtraction and sign fix-up
    always_comb begin
        w_signed  = ~bus.div_op[0];
        w_dbz     = (bus.op_b == ZERO);
        w_ovf     = w_signed && (bus.op_a == MIN_NEG) && (bus.op_b == ALL1);
        w_abs_a   = bus.op_a;
        w_abs_b   = bus.op_b;
        w_special = ALL1;
        if (w_signed && bus.op_a[WORD_WIDTH-1]) begin
            w_abs_a = (~bus.op_a) + ONE;
        end else begin
            w_abs_a = bus.op_a;
        end
        if (w_signed && bus.op_b[WORD_WIDTH-1]) begin
            w_abs_b = (~bus.op_b) + ONE;
        end else begin
            w_abs_b = bus.op_b;
        end
        if (w_dbz) begin
            w_special = bus.div_op[1] ? bus.op_a : ALL1;
        end else begin
            w_special = bus.div_op[1] ? ZERO : MIN_NEG;
        end

        w_trial    = {r_rem, r_dvd[WORD_WIDTH-1]} - {1'b0, r_divisor};
        w_r_signed = ~r_op[0];
        if (w_r_signed && (r_neg_a ^ r_neg_b)) begin
            w_quot = (~r_dvd) + ONE;
        end else begin
            w_quot = r_dvd;
        end
        if (w_r_signed && r_neg_a) begin
            w_remf = (~r_rem) + ONE;
        end else begin
            w_remf = r_rem;
        end
        w_fix_res = r_op[1] ? w_remf : w_quot;
    end

    // Divider state machine with registered result, valid and busy
    always_ff @(posedge CLK) begin
        if (!nrst) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_op      <= 2'b00;
            r_neg_a   <= 1'b0;
            r_neg_b   <= 1'b0;
            r_divisor <= ZERO;
            r_dvd     <= ZERO;
            r_rem     <= ZERO;
            r_res     <= ZERO;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op      <= bus.div_op;
                        r_neg_a   <= w_signed & bus.op_a[WORD_WIDTH-1];
                        r_neg_b   <= w_signed & bus.op_b[WORD_WIDTH-1];
                        r_divisor <= w_abs_b;
                        r_busy    <= 1'b1;
                        if (w_dbz || w_ovf) begin
                            r_res   <= w_special;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt   <= {CW{1'b0}};
                            r_rem   <= ZERO;
                            r_dvd   <= w_abs_a;
                            r_valid <= 1'b0;
                            r_state <= S_CALC;
                        end
                    end else begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (!w_trial[WORD_WIDTH]) begin
                        r_rem <= w_trial[WORD_WIDTH-1:0];
                        r_dvd <= {r_dvd[WORD_WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= {r_rem[WORD_WIDTH-2:0], r_dvd[WORD_WIDTH-1]};
                        r_dvd <= {r_dvd[WORD_WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CNT_END) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_CALC;
                    end
                end
                S_FIX: begin
                    r_res   <= w_fix_res;
                    r_valid <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.res       = r_res;
    assign bus.valid     = r_valid;
    assign bus.busy      = r_busy;
    assign bus.div_stall = bus.start & ~r_valid;
endmodule

// File: tb/tb_divider.sv
// Randomized and directed bench for the divider, checked against an arithmetic
// reference of the RV32M division rules.
module tb_divider;
    logic clk;
    logic nrst;
    int   n_checks;
    int   n_errors;
    logic [31:0] last_exp;

    divider_if #(.WORD_WIDTH(32)) bus ();

    divider #(.WORD_WIDTH(32)) dut (
        .CLK  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // RISC-V semantics with plain 64-bit arithmetic (truncating division)
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one request at a negedge (cycle 0) and hold start until valid
    task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int lat;
        int stall_bad;
        logic [31:0] exp_res;
        exp_res   = ref_div(op, a, b);
        lat       = 0;
        stall_bad = 0;
        bus.start  = 1'b1;
        bus.div_op = op;
        bus.op_a   = a;
        bus.op_b   = b;
        #1;
        check_eq({tag, " stall_c0"}, 32'(bus.div_stall), 32'd1);
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            cyc();
            if (bus.valid) begin
                lat = k;
            end else begin
                if (!bus.div_stall || !bus.busy) stall_bad++;
                bus.op_a = $urandom;
                bus.op_b = $urandom;
                bus.div_op = 2'($urandom_range(0, 3));
            end
        end
        check_eq({tag, " latency"}, 32'(lat), 32'(ref_lat(op, a, b)));
        check_eq({tag, " res"}, bus.res, exp_res);
        check_eq({tag, " stall_busy_during"}, 32'(stall_bad), 32'd0);
        check_eq({tag, " stall_done"}, 32'(bus.div_stall), 32'd0);
        bus.start = 1'b0;
        cyc();
        check_eq({tag, " valid_after"}, {30'd0, bus.valid, bus.busy}, 32'd0);
        last_exp = exp_res;
    endtask

    initial begin
        int vcount;
        int t1, t2;
        logic [31:0] r1, r2;
        logic [1:0]  op;
        logic [31:0] a, b;
        int mode;
        n_checks = 0;
        n_errors = 0;
        nrst = 1'b0;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.div_op = 2'b00;
        bus.op_a = 32'd0;
        bus.op_b = 32'd0;
        cyc();
        cyc();
        check_eq("reset res", bus.res, 32'd0);
        check_eq("reset flags", {29'd0, bus.valid, bus.busy, bus.div_stall}, 32'd0);
        nrst = 1'b1;
        cyc();

        run_div(2'b01, 32'd100, 32'd7, "divu_100_7");
        run_div(2'b11, 32'd100, 32'd7, "remu_100_7");
        run_div(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_div(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_div(2'b00, 32'd7, 32'hFFFF_FFFE, "div_7_m2");
        run_div(2'b01, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
        run_div(2'b00, 32'd5, 32'd0, "div_5_0");
        run_div(2'b11, 32'd5, 32'd0, "remu_5_0");
        run_div(2'b10, 32'h8000_0000, 32'd0, "rem_min_0");
        run_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_div(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
        run_div(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "divu_ovf_ops");
        run_div(2'b00, 32'h8000_0000, 32'd3, "div_min_3");

        // Flush mid-calculation
        bus.start = 1'b1;
        bus.div_op = 2'b01;
        bus.op_a = 32'd1000;
        bus.op_b = 32'd3;
        for (int k = 1; k <= 10; k++) cyc();
        bus.flush = 1'b1;
        bus.start = 1'b0;
        cyc();
        check_eq("flush busy_valid", {30'd0, bus.busy, bus.valid}, 32'd0);
        check_eq("flush res_kept", bus.res, last_exp);
        bus.flush = 1'b0;
        vcount = 0;
        for (int k = 0; k < 40; k++) begin
            cyc();
            if (bus.valid) vcount++;
        end
        check_eq("flush no_valid", 32'(vcount), 32'd0);
        run_div(2'b01, 32'd9, 32'd3, "divu_9_3_post_flush");

        // Reset mid-calculation
        bus.start = 1'b1;
        bus.div_op = 2'b01;
        bus.op_a = 32'd12345;
        bus.op_b = 32'd67;
        for (int k = 1; k <= 20; k++) cyc();
        nrst = 1'b0;
        bus.start = 1'b0;
        cyc();
        check_eq("midreset res", bus.res, 32'd0);
        check_eq("midreset flags", {30'd0, bus.valid, bus.busy}, 32'd0);
        nrst = 1'b1;
        last_exp = 32'd0;
        cyc();

        // Back-to-back with start held high
        bus.start = 1'b1;
        bus.div_op = 2'b01;
        bus.op_a = 32'd50;
        bus.op_b = 32'd5;
        vcount = 0;
        t1 = 0; t2 = 0; r1 = 32'd0; r2 = 32'd0;
        for (int k = 1; k <= 120 && vcount < 2; k++) begin
            cyc();
            if (bus.valid) begin
                vcount++;
                if (vcount == 1) begin
                    t1 = k; r1 = bus.res;
                    bus.op_a = 32'd81;
                    bus.op_b = 32'd9;
                end else begin
                    t2 = k; r2 = bus.res;
                end
            end
        end
        bus.start = 1'b0;
        check_eq("b2b count", 32'(vcount), 32'd2);
        check_eq("b2b first_lat", 32'(t1), 32'd34);
        check_eq("b2b spacing", 32'(t2 - t1), 32'd35);
        check_eq("b2b res1", r1, 32'd10);
        check_eq("b2b res2", r2, 32'd9);
        cyc();
        cyc();

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            mode = $urandom_range(0, 9);
            case (mode)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = 32'd0 - 32'($urandom_range(1, 15));
                4: b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            run_div(op, a, b, $sformatf("rand%0d_op%0d", i, op));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
